// File: rtl/convolution.sv
// convolution
//   Full linear convolution of an 8-sample input sequence with an 8-tap
//   filter. The block recomputes all 15 results every cycle and registers
//   them, so there is one cycle of latency and no handshake.
//
// Ports
//   clk            clock; all state updates on its rising edge
//   rst_n          synchronous active-low reset; clears every output
//   x0..x7  [3:0]  unsigned input samples x[0]..x[7]
//   h0..h7  [3:0]  unsigned filter coefficients h[0]..h[7]
//   y0..y15 [3:0]  registered results y[0]..y[15]; y15 is always 0
//
// Build option
//   CONV_SATURATE_EN  when defined, each output is min(sum, 15);
//                     otherwise each output is the sum modulo 16.

module convolution (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  input  logic [3:0] x3,
  input  logic [3:0] x4,
  input  logic [3:0] x5,
  input  logic [3:0] x6,
  input  logic [3:0] x7,
  input  logic [3:0] h0,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [3:0] h3,
  input  logic [3:0] h4,
  input  logic [3:0] h5,
  input  logic [3:0] h6,
  input  logic [3:0] h7,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [3:0] y4,
  output logic [3:0] y5,
  output logic [3:0] y6,
  output logic [3:0] y7,
  output logic [3:0] y8,
  output logic [3:0] y9,
  output logic [3:0] y10,
  output logic [3:0] y11,
  output logic [3:0] y12,
  output logic [3:0] y13,
  output logic [3:0] y14,
  output logic [3:0] y15
);

  logic [3:0]  x_s  [8];
  logic [3:0]  h_s  [8];
  logic [7:0]  prod [8][8];
  logic [10:0] sum  [15];
  logic [3:0]  y_d  [16];
  logic [3:0]  y_q  [16];

  assign x_s[0] = x0;
  assign x_s[1] = x1;
  assign x_s[2] = x2;
  assign x_s[3] = x3;
  assign x_s[4] = x4;
  assign x_s[5] = x5;
  assign x_s[6] = x6;
  assign x_s[7] = x7;

  assign h_s[0] = h0;
  assign h_s[1] = h1;
  assign h_s[2] = h2;
  assign h_s[3] = h3;
  assign h_s[4] = h4;
  assign h_s[5] = h5;
  assign h_s[6] = h6;
  assign h_s[7] = h7;

  // Every x[k]*h[j] pair, unsigned 4x4 -> 8 bits.
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        prod[k][j] = {4'b0000, x_s[k]} * {4'b0000, h_s[j]};
      end
    end
  end

  // Each product lands in the output index k+j. Eleven bits hold the
  // worst case of eight 225 terms (1800) without overflow.
  always_comb begin
    for (int unsigned n = 0; n < 15; n++) begin
      sum[n] = '0;
    end
    for (int unsigned k = 0; k < 8; k++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        sum[4'(k + j)] = sum[4'(k + j)] + {3'b000, prod[k][j]};
      end
    end
  end

  // Reduce each 11-bit sum to the 4-bit output width.
  always_comb begin
    for (int unsigned n = 0; n < 16; n++) begin
      y_d[n] = '0;
    end
    for (int unsigned n = 0; n < 15; n++) begin
`ifdef CONV_SATURATE_EN
      y_d[n] = (sum[n] > 11'd15) ? 4'hF : sum[n][3:0];
`else
      y_d[n] = sum[n][3:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < 16; n++) begin
        y_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < 16; n++) begin
        y_q[n] <= y_d[n];
      end
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign y4  = y_q[4];
  assign y5  = y_q[5];
  assign y6  = y_q[6];
  assign y7  = y_q[7];
  assign y8  = y_q[8];
  assign y9  = y_q[9];
  assign y10 = y_q[10];
  assign y11 = y_q[11];
  assign y12 = y_q[12];
  assign y13 = y_q[13];
  assign y14 = y_q[14];
  assign y15 = y_q[15];

endmodule

// File: tb/tb_convolution.sv
// tb_convolution
//   Self-checking bench for convolution. Expected outputs come from a
//   plain arithmetic convolution model plus directed constant tables.
//   Honors CONV_SATURATE_EN the same way the design does.

module tb_convolution;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] xv [8];
  logic [3:0] hv [8];
  logic [3:0] yv [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  convolution dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x0 (xv[0]), .x1 (xv[1]), .x2 (xv[2]), .x3 (xv[3]),
    .x4 (xv[4]), .x5 (xv[5]), .x6 (xv[6]), .x7 (xv[7]),
    .h0 (hv[0]), .h1 (hv[1]), .h2 (hv[2]), .h3 (hv[3]),
    .h4 (hv[4]), .h5 (hv[5]), .h6 (hv[6]), .h7 (hv[7]),
    .y0  (yv[0]),  .y1  (yv[1]),  .y2  (yv[2]),  .y3  (yv[3]),
    .y4  (yv[4]),  .y5  (yv[5]),  .y6  (yv[6]),  .y7  (yv[7]),
    .y8  (yv[8]),  .y9  (yv[9]),  .y10 (yv[10]), .y11 (yv[11]),
    .y12 (yv[12]), .y13 (yv[13]), .y14 (yv[14]), .y15 (yv[15])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: y[n] = sum_k x[k]*h[n-k] with integer arithmetic.
  function automatic int model_y(input int n);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      if (n - k >= 0 && n - k <= 7) s += int'(xv[k]) * int'(hv[n - k]);
    end
`ifdef CONV_SATURATE_EN
    return (s > 15) ? 15 : s;
`else
    return s % 16;
`endif
  endfunction

  int exp_y [16];

  // Snapshot the expected outputs for the current inputs/reset, clock
  // once, then compare all 16 outputs 1 time unit after the edge.
  task automatic step_check(input string tag);
    for (int n = 0; n < 16; n++) exp_y[n] = rst_n ? model_y(n) : 0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 16; n++)
      check($sformatf("%s_y%0d", tag, n), int'(yv[n]), exp_y[n]);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) begin
      xv[i] = 4'($urandom_range(0, 15));
      hv[i] = 4'($urandom_range(0, 15));
    end
  endtask

  int tbl [16];
  int hold_y [16];

  initial begin
    rst_n = 1'b0;
    randomize_inputs();

    // Reset held for two edges with arbitrary inputs.
    for (int c = 0; c < 2; c++) begin
      step_check($sformatf("rst%0d", c));
      for (int n = 0; n < 16; n++) check($sformatf("rst_zero%0d_y%0d", c, n), int'(yv[n]), 0);
      randomize_inputs();
    end

    // Ramp x against reversed ramp h, released from reset.
    for (int i = 0; i < 8; i++) begin
      xv[i] = 4'(i + 1);
      hv[i] = 4'(8 - i);
    end
    step_check("ramp_inrst");
    rst_n = 1'b1;
    step_check("ramp");
`ifdef CONV_SATURATE_EN
    tbl = '{15,15,15,15,15,15,15,15,15,15,15,15,15,15,15,0};
`else
    tbl = '{8,7,12,6,4,5,8,12,8,5,4,6,12,7,8,0};
`endif
    for (int n = 0; n < 16; n++) check($sformatf("ramp_tbl_y%0d", n), int'(yv[n]), tbl[n]);

    // Impulse response, then all-zero coefficients one edge later.
    for (int i = 0; i < 8; i++) begin
      xv[i] = (i == 0) ? 4'd1 : 4'd0;
      hv[i] = 4'(i + 1);
    end
    step_check("impulse");
    for (int n = 0; n < 16; n++) check($sformatf("imp_tbl_y%0d", n), int'(yv[n]), (n < 8) ? n + 1 : 0);
    for (int i = 0; i < 8; i++) hv[i] = 4'd0;
    step_check("h_zero");
    for (int n = 0; n < 16; n++) check($sformatf("hz_tbl_y%0d", n), int'(yv[n]), 0);

    // Maximum operands: largest sums and top-bit inputs.
    for (int i = 0; i < 8; i++) begin
      xv[i] = 4'd15;
      hv[i] = 4'd15;
    end
    step_check("max");
`ifdef CONV_SATURATE_EN
    check("max_y0", int'(yv[0]), 15);
    check("max_y7", int'(yv[7]), 15);
`else
    check("max_y0", int'(yv[0]), 1);
    check("max_y7", int'(yv[7]), 8);
`endif
    check("max_y15", int'(yv[15]), 0);

    // Input change between edges must not disturb registered outputs.
    for (int n = 0; n < 16; n++) hold_y[n] = model_y(n);
    randomize_inputs();
    #2;
    for (int n = 0; n < 16; n++) check($sformatf("stable_y%0d", n), int'(yv[n]), hold_y[n]);

    // Reset asserted between edges has no effect until the next edge.
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 16; n++) check($sformatf("async_y%0d", n), int'(yv[n]), hold_y[n]);
    rst_n = 1'b1;

    // Random traffic with single-edge resets sprinkled in mid-stream.
    for (int c = 0; c < 200; c++) begin
      randomize_inputs();
      rst_n = (c % 37 == 20) ? 1'b0 : 1'b1;
      step_check($sformatf("rnd%0d", c));
    end
    rst_n = 1'b1;
    step_check("rnd_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
